sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO and successor to the fixed 8x8 FIFO. It is generalised in data width and depth, and adds programmable almost-full/almost-empty thresholds, an occupancy output, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode. It is the general buffering element between producer and consumer logic in the same clock domain.

---
 rtl/sync_fifo_param.sv | 138 +++++++++++++
 tb/tb_sync_fifo_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, error flags and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_enable,
    input  logic [DATA_W-1:0]            data_in,
    input  logic                         read_enable,
    output logic [DATA_W-1:0]            dout,
    output logic                         dout_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         err_clear
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    // Reject threshold/depth combinations whose flags would be meaningless
    if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_param_check
        $error("sync_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              rd_ok, wr_ok;
    logic [DATA_W-1:0] head;

    // Status flags are a pure decode of the registered occupancy
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign head         = mem_q[rp_q];

    // Access acceptance: a read frees a slot so a write into a full FIFO can proceed
    always_comb begin
        rd_ok = read_enable && !empty;
        wr_ok = write_enable && (!full || rd_ok);
    end

    // Next pointers, occupancy and sticky error flags
    always_comb begin
        wp_d = wp_q;
        rp_d = rp_q;
        count_d = count_q;
        if (wr_ok) begin
            wp_d = (wp_q == LAST_PTR) ? '0 : wp_q + 1'b1;
        end
        if (rd_ok) begin
            rp_d = (rp_q == LAST_PTR) ? '0 : rp_q + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as err_clear keeps the flag set
        overflow_d  = (write_enable && !wr_ok) ? 1'b1 : (err_clear ? 1'b0 : overflow_q);
        underflow_d = (read_enable && !rd_ok)  ? 1'b1 : (err_clear ? 1'b0 : underflow_q);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wp_q        <= '0;
            rp_q        <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array: not reset, and a write during reset is dropped
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem_q[wp_q] <= data_in;
        end
    end

    if (FWFT == 0) begin : g_std_read
        logic [DATA_W-1:0] dout_q, dout_d;
        logic              dout_valid_q, dout_valid_d;

        // Registered read: the popped word lands one cycle after the read, then holds
        always_comb begin
            dout_d       = rd_ok ? head : dout_q;
            dout_valid_d = rd_ok;
        end

        // Read data register
        always_ff @(posedge clk) begin
            if (reset) begin
                dout_q       <= '0;
                dout_valid_q <= 1'b0;
            end else begin
                dout_q       <= dout_d;
                dout_valid_q <= dout_valid_d;
            end
        end

        assign dout       = dout_q;
        assign dout_valid = dout_valid_q;
    end else begin : g_fwft_read
        // Head word is presented directly; masked to zero when nothing is stored so stale data never leaks
        assign dout_valid = !empty;
        assign dout       = dout_valid ? head : '0;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - table, directed and randomized checks of sync_fifo_param against a queue model
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0;
    logic       write_enable = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enable = 1'b0;
    logic       err_clear = 1'b0;

    logic [2:0][7:0] dout_w;
    logic [2:0] dv_w, full_w, empty_w, af_w, ae_w, ov_w, un_w;
    logic [3:0] count8;
    logic [2:0] count5;
    logic [2:0] countf;

    // Instance 0: DEPTH 8 standard, 1: DEPTH 5 standard, 2: DEPTH 4 FWFT
    localparam int MD  [3] = '{8, 5, 4};
    localparam int MAF [3] = '{6, 4, 4};
    localparam int MAE [3] = '{2, 1, 0};
    localparam int MFW [3] = '{0, 0, 1};

    sync_fifo_param #(.DATA_W(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u8 (
        .clk(clk), .reset(reset), .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .dout(dout_w[0]), .dout_valid(dv_w[0]), .full(full_w[0]),
        .empty(empty_w[0]), .almost_full(af_w[0]), .almost_empty(ae_w[0]), .count(count8),
        .overflow(ov_w[0]), .underflow(un_w[0]), .err_clear(err_clear));

    sync_fifo_param #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u5 (
        .clk(clk), .reset(reset), .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .dout(dout_w[1]), .dout_valid(dv_w[1]), .full(full_w[1]),
        .empty(empty_w[1]), .almost_full(af_w[1]), .almost_empty(ae_w[1]), .count(count5),
        .overflow(ov_w[1]), .underflow(un_w[1]), .err_clear(err_clear));

    sync_fifo_param #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(4), .AE_LEVEL(0), .FWFT(1)) uf (
        .clk(clk), .reset(reset), .write_enable(write_enable), .data_in(data_in),
        .read_enable(read_enable), .dout(dout_w[2]), .dout_valid(dv_w[2]), .full(full_w[2]),
        .empty(empty_w[2]), .almost_full(af_w[2]), .almost_empty(ae_w[2]), .count(countf),
        .overflow(ov_w[2]), .underflow(un_w[2]), .err_clear(err_clear));

    int n_checks = 0;
    int n_fail = 0;

    function automatic int cnt_of(int i);
        case (i)
            0:       return int'(count8);
            1:       return int'(count5);
            default: return int'(countf);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural reference: each FIFO is a queue of words plus sticky error bits
    logic [7:0] mq [3][$];
    logic [7:0] mdreg [3];
    logic       mdv [3];
    logic       mov [3];
    logic       mun [3];

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            bit rd;
            bit wr;
            logic [7:0] h;
            if (reset) begin
                mq[i].delete();
                mdreg[i] = 8'h00;
                mdv[i] = 1'b0;
                mov[i] = 1'b0;
                mun[i] = 1'b0;
            end else begin
                rd = read_enable && (mq[i].size() > 0);
                wr = write_enable && ((mq[i].size() < MD[i]) || rd);
                h = 8'h00;
                if (rd) h = mq[i].pop_front();
                if (wr) mq[i].push_back(data_in);
                mdv[i] = rd;
                if (rd) mdreg[i] = h;
                mov[i] = (write_enable && !wr) ? 1'b1 : (err_clear ? 1'b0 : mov[i]);
                mun[i] = (read_enable && !rd) ? 1'b1 : (err_clear ? 1'b0 : mun[i]);
            end
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            int n;
            n = mq[i].size();
            chk($sformatf("m%0d.count", i), cnt_of(i), n);
            chk($sformatf("m%0d.full", i), int'(full_w[i]), int'(n == MD[i]));
            chk($sformatf("m%0d.empty", i), int'(empty_w[i]), int'(n == 0));
            chk($sformatf("m%0d.af", i), int'(af_w[i]), int'(n >= MAF[i]));
            chk($sformatf("m%0d.ae", i), int'(ae_w[i]), int'(n <= MAE[i]));
            chk($sformatf("m%0d.ov", i), int'(ov_w[i]), int'(mov[i]));
            chk($sformatf("m%0d.un", i), int'(un_w[i]), int'(mun[i]));
            if (MFW[i] != 0) begin
                chk($sformatf("m%0d.dv", i), int'(dv_w[i]), int'(n > 0));
                if (n > 0) chk($sformatf("m%0d.dout", i), int'(dout_w[i]), int'(mq[i][0]));
            end else begin
                chk($sformatf("m%0d.dv", i), int'(dv_w[i]), int'(mdv[i]));
                chk($sformatf("m%0d.dout", i), int'(dout_w[i]), int'(mdreg[i]));
            end
        end
    endtask

    task automatic cycle(input logic we, input logic [7:0] din, input logic re,
                         input logic clr, input logic rst);
        write_enable = we;
        data_in = din;
        read_enable = re;
        err_clear = clr;
        reset = rst;
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       re;
        logic       clr;
        logic       rst;
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [7:0] dout;
        logic       dv;
        logic       ov;
        logic       un;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic we, input logic [7:0] din, input logic re, input logic clr,
                       input logic rst, input int cnt, input logic [7:0] dout, input logic dv,
                       input logic ov, input logic un);
        vec_t v;
        v.we = we; v.din = din; v.re = re; v.clr = clr; v.rst = rst;
        v.cnt = cnt;
        v.full = (cnt == 8);
        v.empty = (cnt == 0);
        v.af = (cnt >= 6);
        v.ae = (cnt <= 2);
        v.dout = dout; v.dv = dv; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] fill_seq [8];
        fill_seq = '{8'hA1, 8'hB1, 8'hC1, 8'hD1, 8'hE1, 8'hF1, 8'h1A, 8'h1C};

        // Expected values for the DEPTH=8 standard instance
        add(1, 8'h77, 0, 0, 1, 0, 8'h00, 0, 0, 0);
        add(1, 8'h77, 0, 0, 1, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, fill_seq[i], 0, 0, 0, i + 1, 8'h00, 0, 0, 0);
        add(1, 8'h55, 0, 0, 0, 8, 8'h00, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 8'h00, 1, 0, 0, 7 - i, fill_seq[i], 1, 1, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h1C, 0, 1, 1);
        add(0, 8'h00, 0, 1, 0, 0, 8'h1C, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(1, 8'h10 + 8'(i), 0, 0, 0, i + 1, 8'h1C, 0, 0, 0);
        add(1, 8'h9A, 1, 0, 0, 8, 8'h10, 1, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 8'h00, 1, 0, 0, 7 - i, 8'h11 + 8'(i), 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 8'h9A, 1, 0, 0);
        add(1, 8'hBC, 1, 0, 0, 1, 8'h9A, 0, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1, 8'h9A, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(1, 8'h20 + 8'(i), 0, 0, 0, i + 2, 8'h9A, 0, 0, 0);
        add(1, 8'h66, 0, 1, 0, 8, 8'h9A, 0, 1, 0);
        add(0, 8'h00, 0, 1, 0, 8, 8'h9A, 0, 0, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            cycle(vecs[k].we, vecs[k].din, vecs[k].re, vecs[k].clr, vecs[k].rst);
            chk($sformatf("v%0d.count", k), int'(count8), vecs[k].cnt);
            chk($sformatf("v%0d.full", k), int'(full_w[0]), int'(vecs[k].full));
            chk($sformatf("v%0d.empty", k), int'(empty_w[0]), int'(vecs[k].empty));
            chk($sformatf("v%0d.af", k), int'(af_w[0]), int'(vecs[k].af));
            chk($sformatf("v%0d.ae", k), int'(ae_w[0]), int'(vecs[k].ae));
            chk($sformatf("v%0d.dout", k), int'(dout_w[0]), int'(vecs[k].dout));
            chk($sformatf("v%0d.dv", k), int'(dv_w[0]), int'(vecs[k].dv));
            chk($sformatf("v%0d.ov", k), int'(ov_w[0]), int'(vecs[k].ov));
            chk($sformatf("v%0d.un", k), int'(un_w[0]), int'(vecs[k].un));
        end

        // Reset mid-flight at count=4 discards stored words
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0, 0);
        chk("mid.count_before", int'(count8), 4);
        chk("mid.dout_before", int'(dout_w[0]), 8'h22);
        cycle(0, 8'h00, 0, 0, 1);
        chk("mid.count_after", int'(count8), 0);
        chk("mid.empty_after", int'(empty_w[0]), 1);
        chk("mid.dout_after", int'(dout_w[0]), 8'h00);
        cycle(0, 8'h00, 1, 0, 0);
        chk("mid.read_empty_dv", int'(dv_w[0]), 0);
        chk("mid.read_empty_un", int'(un_w[0]), 1);
        cycle(0, 8'h00, 0, 1, 0);

        // FWFT: word appears without a read, pop reveals the next, then goes invalid
        cycle(1, 8'hDE, 0, 0, 0);
        chk("fwft.dout_write", int'(dout_w[2]), 8'hDE);
        chk("fwft.dv_write", int'(dv_w[2]), 1);
        cycle(0, 8'h00, 0, 0, 0);
        chk("fwft.dout_hold", int'(dout_w[2]), 8'hDE);
        cycle(1, 8'h3F, 0, 0, 0);
        chk("fwft.dout_head", int'(dout_w[2]), 8'hDE);
        cycle(0, 8'h00, 1, 0, 0);
        chk("fwft.dout_next", int'(dout_w[2]), 8'h3F);
        chk("fwft.dv_next", int'(dv_w[2]), 1);
        chk("std.after_reset_first", int'(dout_w[0]), 8'hDE);
        cycle(0, 8'h00, 1, 0, 0);
        chk("fwft.dv_drained", int'(dv_w[2]), 0);
        chk("std.after_reset_second", int'(dout_w[0]), 8'h3F);

        // Randomized bursts, all instances checked against the model every cycle
        for (int blk = 0; blk < 40; blk++) begin
            int pw;
            int pr;
            case (blk % 3)
                0:       begin pw = 85; pr = 20; end
                1:       begin pw = 20; pr = 85; end
                default: begin pw = 60; pr = 60; end
            endcase
            for (int c = 0; c < 20; c++) begin
                cycle(logic'($urandom_range(0, 99) < pw), 8'($urandom),
                      logic'($urandom_range(0, 99) < pr),
                      logic'($urandom_range(0, 99) < 4),
                      logic'($urandom_range(0, 199) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
